fnd_scan_decoder: RTL and testbench

//  Receiving end of the multiplexed 4-digit FND bus (active-low common select + active-low 8-bit font).

---
 rtl/fnd_scan_if.sv | 22 ++
 rtl/fnd_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Multiplexed FND bus (active-low digit select + active-low font) and the decoded results.
// master = bus driver/observer side, slave = the scan decoder.
interface fnd_scan_if;
    logic [3:0] fndCom;
    logic [7:0] fndFont;
    logic [6:0] digit_h;
    logic [6:0] digit_l;
    logic       dot;
    logic       frame_valid;
    logic       seg_error;
    logic       stale;

    modport master (
        output fndCom, fndFont,
        input  digit_h, digit_l, dot, frame_valid, seg_error, stale
    );

    modport slave (
        input  fndCom, fndFont,
        output digit_h, digit_l, dot, frame_valid, seg_error, stale
    );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Snoops a multiplexed 4-digit FND bus, filters scan glitches, decodes each digit
// and republishes complete frames as two 0..99 values plus the dot.
module fnd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    fnd_scan_if.slave  bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // {bad, value}; undecodable glyphs report value 0 with the bad flag set
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = {1'b0, 4'd0};
            7'h79:   decode_seg = {1'b0, 4'd1};
            7'h24:   decode_seg = {1'b0, 4'd2};
            7'h30:   decode_seg = {1'b0, 4'd3};
            7'h19:   decode_seg = {1'b0, 4'd4};
            7'h12:   decode_seg = {1'b0, 4'd5};
            7'h02:   decode_seg = {1'b0, 4'd6};
            7'h78:   decode_seg = {1'b0, 4'd7};
            7'h00:   decode_seg = {1'b0, 4'd8};
            7'h10:   decode_seg = {1'b0, 4'd9};
            default: decode_seg = {1'b1, 4'd0};
        endcase
    endfunction

    function automatic logic [6:0] join_digits(input logic [3:0] tens, input logic [3:0] ones);
        join_digits = ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

    logic [11:0]   sync_p0, sync_p1, hist_p2;
    logic [SW-1:0] settle_cnt, cnt_next;
    logic [TW-1:0] idle_cnt;
    logic [15:0]   digits;
    logic [3:0]    captured, bad, cap_nx, bad_nx;
    logic          dp_cap;
    logic          com_ok, same, capture, dec_bad, frame_done, timeout_hit;
    logic [1:0]    pos;
    logic [3:0]    dec_val;
    logic [6:0]    digit_h_r, digit_l_r;
    logic          dot_r, frame_valid_r, seg_error_r, stale_r;

    always_comb begin
        com_ok = 1'b1;
        pos    = 2'd0;
        case (sync_p1[11:8])
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: com_ok = 1'b0;
        endcase

        same = (sync_p1 == hist_p2);
        if (!com_ok)
            cnt_next = '0;
        else if (same)
            cnt_next = (settle_cnt == SETTLE_MAX) ? SETTLE_MAX : settle_cnt + 1'b1;
        else
            cnt_next = SW'(1);
        // fire only on the cycle the count arrives at the limit, not while parked there
        capture = com_ok && (cnt_next == SETTLE_MAX) && !(same && (settle_cnt == SETTLE_MAX));

        {dec_bad, dec_val} = decode_seg(sync_p1[6:0]);

        frame_done  = (captured == 4'b1111);
        timeout_hit = (idle_cnt == TIMEOUT_LAST) && !capture;

        cap_nx = captured;
        bad_nx = bad;
        if (frame_done || timeout_hit) begin
            cap_nx = '0;
            bad_nx = '0;
        end
        if (capture) begin
            cap_nx[pos] = 1'b1;
            bad_nx[pos] = dec_bad;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0       <= '1;
            sync_p1       <= '1;
            hist_p2       <= '1;
            settle_cnt    <= '0;
            idle_cnt      <= '0;
            digits        <= '0;
            captured      <= '0;
            bad           <= '0;
            dp_cap        <= 1'b1;
            digit_h_r     <= '0;
            digit_l_r     <= '0;
            dot_r         <= 1'b1;
            frame_valid_r <= 1'b0;
            seg_error_r   <= 1'b0;
            stale_r       <= 1'b1;
        end else begin
            // p0 -> p1: two-flop synchronizer; p2 holds the previous synced sample
            sync_p0    <= {bus.fndCom, bus.fndFont};
            sync_p1    <= sync_p0;
            hist_p2    <= sync_p1;
            settle_cnt <= cnt_next;

            if (capture)
                idle_cnt <= '0;
            else if (idle_cnt != TIMEOUT_LAST)
                idle_cnt <= idle_cnt + 1'b1;

            captured <= cap_nx;
            bad      <= bad_nx;
            if (capture) begin
                digits[pos*4 +: 4] <= dec_val;
                if (pos == 2'd2)
                    dp_cap <= sync_p1[7];
            end

            frame_valid_r <= 1'b0;
            if (timeout_hit)
                stale_r <= 1'b1;
            // a clean frame wins over a coincident timeout
            if (frame_done) begin
                if (bad == 4'b0000) begin
                    digit_h_r     <= join_digits(digits[15:12], digits[11:8]);
                    digit_l_r     <= join_digits(digits[7:4], digits[3:0]);
                    dot_r         <= dp_cap;
                    frame_valid_r <= 1'b1;
                    seg_error_r   <= 1'b0;
                    stale_r       <= 1'b0;
                end else begin
                    seg_error_r   <= 1'b1;
                end
            end
        end
    end

    assign bus.digit_h     = digit_h_r;
    assign bus.digit_l     = digit_l_r;
    assign bus.dot         = dot_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.seg_error   = seg_error_r;
    assign bus.stale       = stale_r;
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench for fnd_scan_decoder: stimulus pushes expected frames, a monitor
// pops and compares them on every frame_valid pulse.
module tb_fnd_scan_decoder;
    logic clk;
    logic reset;

    fnd_scan_if bus ();

    fnd_scan_decoder #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int h;
        int l;
        int d;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'h40;
            1: seg_of = 7'h79;
            2: seg_of = 7'h24;
            3: seg_of = 7'h30;
            4: seg_of = 7'h19;
            5: seg_of = 7'h12;
            6: seg_of = 7'h02;
            7: seg_of = 7'h78;
            8: seg_of = 7'h00;
            default: seg_of = 7'h10;
        endcase
    endfunction

    // called on a negedge; holds the bus value for n cycles
    task automatic drive(input logic [3:0] com, input logic [7:0] font, input int n);
        bus.fndCom  = com;
        bus.fndFont = font;
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input int p, input int d, input bit dp_lit, input int n);
        logic [3:0] c;
        c = 4'b0001 << p;
        drive(~c, {~dp_lit, seg_of(d)}, n);
    endtask

    task automatic scan(input int h, input int l, input bit dot_lit);
        put(0, l % 10, 1'b0, 100);
        put(1, l / 10, 1'b0, 100);
        put(2, h % 10, dot_lit, 100);
        put(3, h / 10, 1'b0, 100);
    endtask

    task automatic blank(input int n);
        drive(4'hF, 8'hFF, n);
    endtask

    task automatic expect_drained(input string name);
        check({name, " pending frames"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset && bus.frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected frame_valid", 1, 0);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame digit_h", int'(bus.digit_h), e.h);
                check("frame digit_l", int'(bus.digit_l), e.l);
                check("frame dot", int'(bus.dot), e.d);
                check("frame seg_error", int'(bus.seg_error), 0);
                check("frame stale", int'(bus.stale), 0);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.fndCom  = 4'hF;
        bus.fndFont = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset digit_h", int'(bus.digit_h), 0);
        check("reset digit_l", int'(bus.digit_l), 0);
        check("reset dot", int'(bus.dot), 1);
        check("reset frame_valid", int'(bus.frame_valid), 0);
        check("reset seg_error", int'(bus.seg_error), 0);
        check("reset stale", int'(bus.stale), 1);
        reset = 1'b0;
        blank(5);

        // 12:34 with the dot lit on pos2
        exp_q.push_back('{12, 34, 0});
        scan(12, 34, 1'b1);
        blank(10);
        expect_drained("t1");

        // 'A' glyph at pos1 poisons the frame; outputs must hold
        put(0, 4, 1'b0, 100);
        drive(4'b1101, 8'h88, 100);
        put(2, 2, 1'b0, 100);
        put(3, 1, 1'b0, 100);
        blank(10);
        check("bad frame seg_error", int'(bus.seg_error), 1);
        check("bad frame digit_h hold", int'(bus.digit_h), 12);
        check("bad frame digit_l hold", int'(bus.digit_l), 34);
        check("bad frame dot hold", int'(bus.dot), 0);
        exp_q.push_back('{9, 0, 1});
        scan(9, 0, 1'b0);
        blank(10);
        expect_drained("t3");

        // 56:78 with short pos1 glitches between digits
        exp_q.push_back('{56, 78, 1});
        put(0, 8, 1'b0, 100);
        drive(4'b1101, 8'hF9, 2);
        put(1, 7, 1'b0, 100);
        drive(4'b1101, 8'hF9, 2);
        put(2, 6, 1'b0, 100);
        drive(4'b1101, 8'hF9, 2);
        put(3, 5, 1'b0, 100);
        blank(10);
        check("glitch digit_l", int'(bus.digit_l), 78);
        expect_drained("t2");

        // timeout discards the partial frame
        put(0, 1, 1'b0, 100);
        put(1, 2, 1'b0, 100);
        check("partial no stale", int'(bus.stale), 0);
        blank(1100);
        check("timeout stale", int'(bus.stale), 1);
        put(2, 3, 1'b0, 100);
        put(3, 4, 1'b0, 100);
        check("after timeout stale held", int'(bus.stale), 1);
        check("after timeout digit_h hold", int'(bus.digit_h), 56);
        exp_q.push_back('{43, 21, 1});
        put(0, 1, 1'b0, 100);
        put(1, 2, 1'b0, 100);
        blank(10);
        expect_drained("t4");

        // reset mid-frame
        put(0, 9, 1'b0, 100);
        put(1, 9, 1'b0, 100);
        blank(5);
        #2 reset = 1'b1;
        #1;
        check("midreset digit_h", int'(bus.digit_h), 0);
        check("midreset digit_l", int'(bus.digit_l), 0);
        check("midreset dot", int'(bus.dot), 1);
        check("midreset stale", int'(bus.stale), 1);
        check("midreset seg_error", int'(bus.seg_error), 0);
        @(negedge clk);
        reset = 1'b0;
        blank(5);
        put(2, 9, 1'b0, 100);
        put(3, 9, 1'b0, 100);
        exp_q.push_back('{99, 99, 1});
        put(0, 9, 1'b0, 100);
        put(1, 9, 1'b0, 100);
        blank(10);
        expect_drained("t5");

        // pos0 recaptured with a new value before the frame closes
        exp_q.push_back('{0, 2, 1});
        drive(4'b1110, 8'hF9, 100);
        drive(4'b1110, 8'hA4, 100);
        put(1, 0, 1'b0, 100);
        put(2, 0, 1'b0, 100);
        put(3, 0, 1'b0, 100);
        blank(10);
        check("recapture digit_l", int'(bus.digit_l), 2);
        expect_drained("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
